addsub_rr_scheduler: RTL and testbench
======================================

// Module: addsub_rr_scheduler
// PURPOSE
//  Shares one combinational adder-substractor datapath between NREQ requesters.
//  Round-robin arbitration picks one request, drives the datapath operands and mode, and
//  registers the result. The result is returned on a single response channel tagged with
//  the requester id. A sticky error flag records any datapath result that mismatches the
//  expected value.
// PARAMETERS
//  NREQ  4  number of requesters (>=2)
//  W     4  operand width; result width is W+1
// PORTS
//  clk         in   1        clock, rising edge
//  rst_n       in   1        asynchronous active-low reset
//  req_valid   in   NREQ     per-requester request valid
//  req_ready   out  NREQ     per-requester accept (one-hot or zero)
//  req_a       in   NREQ*W   operand a, requester i at [i*W +: W]
//  req_b       in   NREQ*W   operand b, same packing
//  req_mode    in   NREQ     0 = add, 1 = subtract
//  au_a        out  W        shared datapath operand a
//  au_b        out  W        shared datapath operand b
//  au_mode     out  1        shared datapath mode
//  au_out      in   W+1      shared datapath result (combinational from au_*)
//  rsp_valid   out  1        response valid
//  rsp_ready   in   1        response accept from consumer
//  rsp_id      out  clog2(NREQ)  index of the served requester
//  rsp_result  out  W+1      registered result
//  err         out  1        sticky: au_out != expected in some EXEC cycle
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, rr_ptr=0, au_a/au_b/au_mode=0, rsp_valid=0,
//   rsp_id=0, rsp_result=0, err=0. req_ready=0 while rst_n=0.
//   An in-flight transaction is dropped: no response, no ready re-issued.
//  FSM states:
//   IDLE: if |req_valid, winner = first i with req_valid[i], searching rr_ptr,
//    rr_ptr+1, ... mod NREQ. req_ready[winner]=1 (combinational, this cycle only).
//    Latch winner's a, b, mode into au_* and winner into rsp_id. Go to EXEC.
//    If no request, stay in IDLE with req_ready=0.
//   EXEC: au_* held stable. At the clock edge: rsp_result<=au_out, go to RESP.
//    If au_out != expected, set err<=1.
//    expected = mode ? ({1'b0,a}-{1'b0,b}) mod 2^(W+1) : {1'b0,a}+{1'b0,b}.
//   RESP: rsp_valid=1; rsp_id and rsp_result held stable until accepted.
//    On rsp_valid&&rsp_ready: rr_ptr<=(rsp_id+1) mod NREQ, rsp_valid<=0, go to IDLE.
//  req_ready is 0 in EXEC and RESP. A request asserted during RESP is first considered
//   in the IDLE cycle after the handshake. Minimum 3 cycles per transaction.
//  Requester protocol: req_valid must stay high, and operands stay stable, until
//   req_ready. The scheduler does not check this.
//  au_* keep their last value outside EXEC; they are not cleared.
//  err clears only on reset.
//  rr_ptr updates only on response handshake, never on acceptance.
//  Arithmetic: subtract wraps in W+1 bits (W=4: 3-5 = 5'h1E; 15+15 = 5'h1E).
// TESTING
//  1 Reset: rst_n=0 mid-EXEC -> rsp_valid=0, err=0, rr_ptr=0; no response after release.
//  2 Single add: req0 a=9 b=8 mode=0, rsp_ready=1 -> req_ready[0] in cycle 0;
//    rsp_valid in cycle 2 with id=0, result=5'h11.
//  3 Subtract wrap: req2 a=3 b=5 mode=1 -> rsp_id=2, rsp_result=5'h1E.
//  4 Fairness: all 4 valid continuously, rsp_ready=1 -> served in order 0,1,2,3,0.
//    One response every 3 cycles.
//  5 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable.
//    No req_ready asserted; rr_ptr unchanged until the handshake.
//  6 Datapath fault: force au_out=0 for a=1 b=1 add -> err=1 and stays 1.
//    rsp_result=0 is still delivered.

Source files
------------

// File: rtl/addsub_rr_scheduler.sv
// Purpose : round-robin scheduler sharing one combinational add/sub datapath among NREQ requesters.
// Latency : accept in cycle 0, datapath in cycle 1, response valid from cycle 2 (3 cycles minimum per transaction).
// Backpress: rsp_* are held while rsp_ready=0, and no new request is accepted until the response handshake.
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready             per-requester handshake; req_ready is one-hot or zero
//   req_a/req_b/req_mode            packed operands (requester i at [i*W +: W]) and mode (1 = subtract)
//   au_a/au_b/au_mode/au_out        shared external datapath; au_out is combinational from au_*
//   rsp_valid/rsp_ready             response handshake
//   rsp_id/rsp_result               served requester index and registered W+1-bit result
//   err                             sticky datapath-mismatch flag, cleared only by reset
module addsub_rr_scheduler #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    input  logic [NREQ-1:0]     req_mode,
    output logic [W-1:0]        au_a,
    output logic [W-1:0]        au_b,
    output logic                au_mode,
    input  logic [W:0]          au_out,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [W:0]          rsp_result,
    output logic                err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;

    // ------------------------------------------------------------------
    // Round-robin winner search, starting at rr_ptr and wrapping.
    // ------------------------------------------------------------------
    logic            grant_any;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  cand;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(rr_ptr) + k) % NREQ);
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_any && (IDW'(i) == cand) && req_valid[i]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    // Operand mux for the winner; constant loop indices keep part-selects static.
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic            sel_mode;

    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_mode = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == grant_idx) begin
                sel_a    = req_a[i*W +: W];
                sel_b    = req_b[i*W +: W];
                sel_mode = req_mode[i];
            end
        end
    end

    // Acceptance is combinational and only in IDLE; forced low while reset is asserted.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = rst_n && (state == ST_IDLE) && grant_any && (IDW'(i) == grant_idx);
        end
    end

    // Reference result for the datapath self-check; both branches wrap in W+1 bits.
    logic [W:0]      exp_res;
    assign exp_res = au_mode ? ({1'b0, au_a} - {1'b0, au_b})
                             : ({1'b0, au_a} + {1'b0, au_b});

    // Pointer moves past the served requester, only when its response is taken.
    logic [IDW-1:0]  ptr_next;
    assign ptr_next = (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;

    // ------------------------------------------------------------------
    // Transaction FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            au_a       <= '0;
            au_b       <= '0;
            au_mode    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        au_a    <= sel_a;
                        au_b    <= sel_b;
                        au_mode <= sel_mode;
                        rsp_id  <= grant_idx;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // au_* are stable here, so au_out has settled for this operand set.
                    rsp_result <= au_out;
                    if (au_out != exp_res) begin
                        err <= 1'b1;
                    end
                    rsp_valid  <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= ptr_next;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Protocol properties.
    // ------------------------------------------------------------------
    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));

    a_ready_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (state != ST_IDLE) |-> (req_ready == '0));

    a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_id) && $stable(rsp_result)));

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Purpose : self-checking bench for addsub_rr_scheduler against a transaction-level model.
// Latency : samples on the falling edge, drives 1 time unit after the rising edge.
// Backpress: rsp_ready is driven by directed sequences and by random stalls.
module tb_addsub_rr_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;
    localparam int MOD  = 1 << (W + 1);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_a = '0;
    logic [NREQ*W-1:0]   req_b = '0;
    logic [NREQ-1:0]     req_mode = '0;
    logic [W-1:0]        au_a;
    logic [W-1:0]        au_b;
    logic                au_mode;
    logic [W:0]          au_out;
    logic                rsp_valid;
    logic                rsp_ready = 1'b1;
    logic [IDW-1:0]      rsp_id;
    logic [W:0]          rsp_result;
    logic                err;
    logic                fault = 1'b0;

    always #5 clk = ~clk;

    // External datapath; asserting fault forces its output to zero.
    assign au_out = fault ? '0 : (au_mode ? ({1'b0, au_a} - {1'b0, au_b})
                                          : ({1'b0, au_a} + {1'b0, au_b}));

    addsub_rr_scheduler #(.NREQ(NREQ), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_mode   (req_mode),
        .au_a       (au_a),
        .au_b       (au_b),
        .au_mode    (au_mode),
        .au_out     (au_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .err        (err)
    );

    // Requester-side state.
    bit           pv [NREQ];
    int           pa [NREQ];
    int           pb [NREQ];
    bit           pm [NREQ];
    bit           refill = 1'b0;

    // Transaction-level model.
    int           ptr = 0;
    bit           busy = 1'b0;
    int           k = 0;
    int           exp_id = 0;
    int           true_res = 0;
    int           exp_res = 0;
    bit           txn_fault = 1'b0;
    bit           err_exp = 1'b0;
    int           drop = -1;
    int           cyc = 0;
    int           served [$];
    int           hs_cyc [$];

    int           n_chk = 0;
    int           n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = pv[i];
            req_a[i*W +: W]    = W'(pa[i]);
            req_b[i*W +: W]    = W'(pb[i]);
            req_mode[i]        = pm[i];
        end
    endtask

    task automatic set_req(input int i, input int a, input int b, input bit m);
        pv[i] = 1'b1;
        pa[i] = a;
        pb[i] = b;
        pm[i] = m;
        pack();
    endtask

    function automatic bit any_pending();
        bit r = 1'b0;
        for (int i = 0; i < NREQ; i++) r |= pv[i];
        return r;
    endfunction

    task automatic model_reset();
        busy    = 1'b0;
        ptr     = 0;
        err_exp = 1'b0;
        drop    = -1;
    endtask

    // One clock: check at the falling edge, then apply requester updates after the rising edge.
    task automatic step();
        int win;
        logic [NREQ-1:0] exp_rdy;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            check("rst_req_ready", 32'(req_ready), 32'(0));
            check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
            check("rst_err", 32'(err), 32'(0));
            check("rst_au", 32'({au_a, au_b, au_mode}), 32'(0));
            check("rst_rsp", 32'({rsp_id, rsp_result}), 32'(0));
        end else if (!busy) begin
            win = -1;
            for (int j = 0; j < NREQ; j++) begin
                int idx = (ptr + j) % NREQ;
                if (win < 0 && pv[idx]) win = idx;
            end
            for (int i = 0; i < NREQ; i++) exp_rdy[i] = (i == win);
            check("req_ready_idle", 32'(req_ready), 32'(exp_rdy));
            check("rsp_valid_idle", 32'(rsp_valid), 32'(0));
            check("err_idle", 32'(err), 32'(err_exp));
            if (win >= 0) begin
                busy      = 1'b1;
                k         = 0;
                exp_id    = win;
                true_res  = pm[win] ? ((pa[win] - pb[win] + MOD) % MOD) : (pa[win] + pb[win]);
                txn_fault = fault;
                exp_res   = fault ? 0 : true_res;
                drop      = win;
            end
        end else begin
            k++;
            if (k == 2 && txn_fault && true_res != 0) err_exp = 1'b1;
            check("req_ready_busy", 32'(req_ready), 32'(0));
            check("err_busy", 32'(err), 32'(err_exp));
            if (k == 1) begin
                check("rsp_valid_exec", 32'(rsp_valid), 32'(0));
            end else begin
                check("rsp_valid_resp", 32'(rsp_valid), 32'(1));
                check("rsp_id", 32'(rsp_id), exp_id);
                check("rsp_result", 32'(rsp_result), exp_res);
                if (rsp_ready) begin
                    busy = 1'b0;
                    ptr  = (exp_id + 1) % NREQ;
                    served.push_back(exp_id);
                    hs_cyc.push_back(cyc);
                end
            end
        end
        @(posedge clk);
        #1;
        if (drop >= 0) begin
            pv[drop] = 1'b0;
            if (refill) set_req(drop, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
            drop = -1;
            pack();
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || any_pending()) && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) check("drain_timeout", 32'(1), 32'(0));
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            pv[i] = 1'b0; pa[i] = 0; pb[i] = 0; pm[i] = 1'b0;
        end
        pack();
        model_reset();
        step(); step(); step();
        rst_n = 1'b1;
        step();

        // Single add on requester 0.
        set_req(0, 9, 8, 1'b0);
        drain();

        // Subtract with wrap on requester 2.
        set_req(2, 3, 5, 1'b1);
        drain();

        // Backpressure in RESP on requester 3, with new requests arriving meanwhile.
        rsp_ready = 1'b0;
        set_req(3, 7, 12, 1'b1);
        for (int n = 0; n < 10 && !(busy && k >= 2); n++) step();
        set_req(0, 15, 15, 1'b0);
        set_req(3, 6, 2, 1'b0);
        for (int n = 0; n < 5; n++) step();
        rsp_ready = 1'b1;
        drain();

        // Fairness: all requesters valid continuously.
        served.delete();
        hs_cyc.delete();
        refill = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
        for (int n = 0; n < 18; n++) step();
        refill = 1'b0;
        drain();
        for (int i = 0; i < 5; i++) begin
            if (i < served.size()) check("fair_order", served[i], i % NREQ);
            else check("fair_missing", 32'(0), 32'(1));
        end
        for (int i = 1; i < 5; i++) begin
            if (i < hs_cyc.size()) check("fair_rate", hs_cyc[i] - hs_cyc[i-1], 3);
        end

        // Datapath fault: result 0 delivered, err sticks afterwards.
        fault = 1'b1;
        set_req(1, 1, 1, 1'b0);
        drain();
        fault = 1'b0;
        set_req(1, 4, 9, 1'b1);
        drain();
        check("err_sticky", 32'(err), 32'(1));

        // Reset while in EXEC: transaction dropped, pointer back to 0, err cleared.
        set_req(3, 10, 3, 1'b0);
        step();
        rst_n = 1'b0;
        model_reset();
        set_req(1, 2, 2, 1'b0);
        set_req(2, 5, 1, 1'b1);
        step(); step();
        set_req(0, 8, 8, 1'b0);
        rst_n = 1'b1;
        drain();

        // Random traffic with random response stalls.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && $urandom_range(0, 3) == 0)
                    set_req(i, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        rsp_ready = 1'b1;
        drain();
        check("final_err", 32'(err), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
